// File: rtl/io_pkg.sv
// ============================================================================
//  Module      : io_pkg
//  Description : Shared widths and I/O address map for the input/output ports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_pkg;

    localparam int IO_DATA_W = 32;
    localparam int IO_SEL_W  = 6;

    // Word selects, i.e. addr[7:2] of byte addresses 0xC0 and 0xC4.
    localparam logic [IO_SEL_W-1:0] IO_IN0_SEL = 6'b110000;
    localparam logic [IO_SEL_W-1:0] IO_IN1_SEL = 6'b110001;

    typedef enum logic [1:0] {
        IO_SRC_NONE  = 2'd0,
        IO_SRC_PORT0 = 2'd1,
        IO_SRC_PORT1 = 2'd2
    } io_src_e;

endpackage : io_pkg

`default_nettype wire

// File: rtl/io_input_mux_if.sv
// ============================================================================
//  Module      : io_input_mux_if
//  Description : Port bundle between the input-port registers and the read mux.
//                addr_hit exists only when IO_INPUT_MUX_HIT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface io_input_mux_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 6
);

    logic [DATA_W-1:0] in_reg0;
    logic [DATA_W-1:0] in_reg1;
    logic [SEL_W-1:0]  sel_addr;
    logic [DATA_W-1:0] io_read_data;
`ifdef IO_INPUT_MUX_HIT_EN
    logic              addr_hit;
`endif

    modport master (
        output in_reg0,
        output in_reg1,
        output sel_addr,
`ifdef IO_INPUT_MUX_HIT_EN
        input  addr_hit,
`endif
        input  io_read_data
    );

    modport slave (
        input  in_reg0,
        input  in_reg1,
        input  sel_addr,
`ifdef IO_INPUT_MUX_HIT_EN
        output addr_hit,
`endif
        output io_read_data
    );

endinterface : io_input_mux_if

`default_nettype wire

// File: rtl/io_input_mux.sv
// ============================================================================
//  Module      : io_input_mux
//  Description : Registered read-data selector for the memory-mapped input
//                ports. Optional registered addr_hit via IO_INPUT_MUX_HIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_input_mux
    import io_pkg::*;
#(
    parameter int                DATA_W    = IO_DATA_W,
    parameter int                SEL_W     = IO_SEL_W,
    parameter logic [SEL_W-1:0]  PORT0_SEL = IO_IN0_SEL,
    parameter logic [SEL_W-1:0]  PORT1_SEL = IO_IN1_SEL
) (
    input  wire logic     io_clk,
    input  wire logic     reset,
    io_input_mux_if.slave bus
);

    io_src_e           src;
    logic [DATA_W-1:0] io_read_data_d;
    logic [DATA_W-1:0] io_read_data_q;

    // Full-width compare; the first matching item wins, so port 0 takes
    // priority if both selects are configured identically. X/Z selects
    // match neither item and fall to the zero default.
    always_comb begin
        src = IO_SRC_NONE;
        case (bus.sel_addr)
            PORT0_SEL: src = IO_SRC_PORT0;
            PORT1_SEL: src = IO_SRC_PORT1;
            default:   src = IO_SRC_NONE;
        endcase
    end

    always_comb begin
        io_read_data_d = '0;
        case (src)
            IO_SRC_PORT0: io_read_data_d = bus.in_reg0;
            IO_SRC_PORT1: io_read_data_d = bus.in_reg1;
            default:      io_read_data_d = '0;
        endcase
    end

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            io_read_data_q <= '0;
        end else begin
            io_read_data_q <= io_read_data_d;
        end
    end

    assign bus.io_read_data = io_read_data_q;

`ifdef IO_INPUT_MUX_HIT_EN
    logic addr_hit_d;
    logic addr_hit_q;

    always_comb begin
        addr_hit_d = (src != IO_SRC_NONE);
    end

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            addr_hit_q <= 1'b0;
        end else begin
            addr_hit_q <= addr_hit_d;
        end
    end

    assign bus.addr_hit = addr_hit_q;
`endif

endmodule : io_input_mux

`default_nettype wire

// File: tb/tb_io_input_mux.sv
// ============================================================================
//  Module      : tb_io_input_mux
//  Description : Self-checking bench for io_input_mux (directed + random).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_input_mux;
    import io_pkg::*;

    logic io_clk = 1'b0;
    logic reset  = 1'b1;
    int   n_cmp  = 0;
    int   n_err  = 0;
    logic [31:0] exp_data = '0;
    logic        exp_hit  = 1'b0;

    io_input_mux_if #(.DATA_W(IO_DATA_W), .SEL_W(IO_SEL_W)) bus ();

    io_input_mux dut (
        .io_clk (io_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 io_clk = ~io_clk;

    // Reference: reconstruct the byte address and look it up in the I/O map.
    function automatic logic [31:0] model_data(logic [5:0] sel, logic [31:0] r0, logic [31:0] r1);
        int byte_addr;
        byte_addr = int'(sel) * 4;
        if (byte_addr == 'hC0) return r0;
        if (byte_addr == 'hC4) return r1;
        return 32'd0;
    endfunction

    function automatic logic model_hit(logic [5:0] sel);
        int byte_addr;
        byte_addr = int'(sel) * 4;
        return (byte_addr == 'hC0) || (byte_addr == 'hC4);
    endfunction

    task automatic check(string tag);
        n_cmp++;
        assert (bus.io_read_data === exp_data) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, bus.io_read_data, exp_data);
        end
`ifdef IO_INPUT_MUX_HIT_EN
        n_cmp++;
        assert (bus.addr_hit === exp_hit) else begin
            n_err++;
            $error("FAIL %s_hit: observed %b expected %b", tag, bus.addr_hit, exp_hit);
        end
`endif
    endtask

    // Drive at the falling edge, let one rising edge pass, sample 1 ns later.
    task automatic step(logic [5:0] sel, logic [31:0] r0, logic [31:0] r1, string tag);
        @(negedge io_clk);
        bus.sel_addr = sel;
        bus.in_reg0  = r0;
        bus.in_reg1  = r1;
        @(posedge io_clk);
        #1;
        if (!reset) begin
            exp_data = model_data(sel, r0, r1);
            exp_hit  = model_hit(sel);
        end
        check(tag);
    endtask

    initial begin
        logic [5:0]  rs;
        logic [31:0] r0;
        logic [31:0] r1;

        // Reset asserted from time zero.
        bus.in_reg0  = 32'h1F;
        bus.in_reg1  = 32'h0A;
        bus.sel_addr = 6'b110000;
        #1;
        check("reset_async");
        for (int i = 0; i < 3; i++) step(6'b110000, 32'h1F, 32'h0A, "reset_held");

        @(negedge io_clk);
        reset = 1'b0;
        step(6'b110000, 32'h1F, 32'h0A, "first_after_reset");

        // Port 1 select; output must hold until the next edge.
        @(negedge io_clk);
        bus.sel_addr = 6'b110001;
        bus.in_reg1  = 32'h15;
        #1;
        check("hold_before_edge");
        step(6'b110001, 32'h0, 32'h15, "port1_select");

        for (int i = 0; i < 6; i++)
            step((i % 2 == 0) ? 6'b110000 : 6'b110001, 32'h3, 32'h1C, "alternate");

        step(6'b000000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "unmapped_000000");
        step(6'b110010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "unmapped_110010");
        step(6'b111111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "unmapped_111111");
        step(6'b100000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "unmapped_100000");
        step(6'b110001, 32'h0, 32'h1C, "pre_midreset");

        // Reset between edges must clear the output without a clock.
        #2;
        reset = 1'b1;
        #1;
        exp_data = '0;
        exp_hit  = 1'b0;
        check("midcycle_reset");
        step(6'b110001, 32'h0, 32'h1C, "reset_held_edge");
        @(negedge io_clk);
        reset = 1'b0;
        step(6'b110001, 32'h0, 32'h55AA_33CC, "after_midreset");

        // Random traffic biased towards the two mapped selects.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       rs = 6'b110000;
                1:       rs = 6'b110001;
                2:       rs = 6'(6'b110000 ^ (6'd1 << $urandom_range(0, 5)));
                default: rs = 6'($urandom);
            endcase
            r0 = $urandom;
            r1 = $urandom;
            step(rs, r0, r1, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_io_input_mux

`default_nettype wire
